// File: rtl/serial_cmp_pkg.sv
// Shared types and result encodings for the bit-serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One-hot result vector ordered {lesser, greater, equal}.
  localparam logic [2:0] RES_EQ = 3'b001;
  localparam logic [2:0] RES_GT = 3'b010;
  localparam logic [2:0] RES_LT = 3'b100;

endpackage

// File: rtl/cmp_bit_cell.sv
// Single-bit MSB-first decision: flags the first differing bit as A>B or A<B.
module cmp_bit_cell (
  input  logic ab,
  input  logic bb,
  input  logic is_sign_bit,
  input  logic signed_mode,
  input  logic decided,
  output logic set_gt,
  output logic set_lt
);

  logic differ;
  logic a_wins;

  assign differ = (ab != bb) && !decided;
  // At the sign bit of a two's complement operand a 0 means the larger value.
  assign a_wins = (is_sign_bit && signed_mode) ? !ab : ab;
  assign set_gt = differ && a_wins;
  assign set_lt = differ && !a_wins;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial signed/unsigned magnitude comparator, MSB-first, start/busy/done handshake.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish on the first differing bit instead of after WIDTH bits.
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             greater,
  output logic             lesser
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic               signed_q, signed_d;
  logic               decided_q, decided_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               eq_q, eq_d;
  logic               gt_q, gt_d;
  logic               lt_q, lt_d;
  logic               load;
  logic               set_gt, set_lt;

  cmp_bit_cell u_cell (
    .ab          (a_sh_q[WIDTH-1]),
    .bb          (b_sh_q[WIDTH-1]),
    .is_sign_bit (cnt_q == CNT_W'(WIDTH)),
    .signed_mode (signed_q),
    .decided     (decided_q),
    .set_gt      (set_gt),
    .set_lt      (set_lt)
  );

  assign load = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    signed_d  = signed_q;
    decided_d = decided_q;
    cnt_d     = cnt_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;

    case (state_q)
      IDLE:  state_d = IDLE;
      SHIFT: begin
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q << 1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (set_gt || set_lt) begin
          decided_d = 1'b1;
          gt_d      = set_gt;
          lt_d      = set_lt;
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          if (!decided_q && !set_gt && !set_lt) eq_d = 1'b1;
        end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (set_gt || set_lt) state_d = DONE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An accepted start clears the previous result on the edge it latches operands.
    if (load) begin
      state_d   = SHIFT;
      a_sh_d    = a;
      b_sh_d    = b;
      signed_d  = signed_mode;
      decided_d = 1'b0;
      cnt_d     = CNT_W'(WIDTH);
      eq_d      = 1'b0;
      gt_d      = 1'b0;
      lt_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      signed_q  <= 1'b0;
      decided_q <= 1'b0;
      cnt_q     <= '0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      signed_q  <= signed_d;
      decided_q <= decided_d;
      cnt_q     <= cnt_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
    end
  end

  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);
  assign equal   = eq_q;
  assign greater = gt_q;
  assign lesser  = lt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for the 4-bit build: driver pushes expected results, monitor checks at done.
module tb_serial_magnitude_comparator;
  import serial_cmp_pkg::*;

  localparam int W = 4;

  typedef struct {
    logic [2:0] res;
    int         done_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, equal, greater, lesser;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  serial_magnitude_comparator #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .equal       (equal),
    .greater     (greater),
    .lesser      (lesser)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [2:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
    if (sm) begin
      if ($signed(x) > $signed(y)) return RES_GT;
      if ($signed(x) < $signed(y)) return RES_LT;
    end else begin
      if (x > y) return RES_GT;
      if (x < y) return RES_LT;
    end
    return RES_EQ;
  endfunction

  // Cycles from the start edge to the cycle in which done is high.
  function automatic int latency(input logic [W-1:0] x, input logic [W-1:0] y);
    int lat;
    lat = W + 1;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i] != y[i]) begin
        lat = (W - i) + 1;
        break;
      end
    end
`endif
    return lat;
  endfunction

  // Called at a negedge; waits for ready, issues one compare, returns at the negedge after the start edge.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic sm,
                       input logic [2:0] res);
    int   guard;
    exp_t e;
    guard = 0;
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (busy) check("ready_timeout", 32'(busy), 32'd0);
    a = ta;
    b = tb_v;
    signed_mode = sm;
    start = 1'b1;
    e.res = res;
    e.done_cyc = cyc + latency(ta, tb_v);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = ~ta;
    b = ~tb_v;
    signed_mode = ~sm;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      check("onehot_result", 32'($countones({lesser, greater, equal})), 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", 32'({lesser, greater, equal}), 32'(e.res));
        check("done_cycle", 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_results", 32'({lesser, greater, equal}), 32'd0);

    // 1001 vs 0011 unsigned: busy for every shift cycle, then A greater.
    issue(4'b1001, 4'b0011, 1'b0, RES_GT);
    for (int i = 0; i < latency(4'b1001, 4'b0011) - 1; i++) begin
      check("busy_in_shift", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check("done_after_shift", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    check("result_holds_idle", 32'({lesser, greater, equal}), 32'(RES_GT));

    issue(4'b1001, 4'b0011, 1'b1, RES_LT);  // -7 vs 3
    issue(4'b1111, 4'b1111, 1'b0, RES_EQ);
    issue(4'b1111, 4'b1111, 1'b1, RES_EQ);
    issue(4'b1000, 4'b0111, 1'b0, RES_GT);  // MSB decides, unsigned
    issue(4'b1000, 4'b0111, 1'b1, RES_LT);  // -8 vs 7
    issue(4'b0110, 4'b0111, 1'b1, RES_LT);  // LSB decides
    issue(4'b0000, 4'b1111, 1'b1, RES_GT);  // 0 vs -1
    drain();

    // start held high: only pairs presented while ready are compared.
    begin
      logic [W-1:0] pa[4] = '{4'h3, 4'hA, 4'hA, 4'h7};
      logic [W-1:0] pb[4] = '{4'h5, 4'h2, 4'h2, 4'h7};
      logic         ps[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [2:0]   pr[4] = '{RES_LT, RES_LT, RES_GT, RES_EQ};
      int idx, guard;
      exp_t e;
      idx = 0;
      guard = 0;
      start = 1'b1;
      while (idx < 4 && guard < 100) begin
        if (!busy) begin
          a = pa[idx];
          b = pb[idx];
          signed_mode = ps[idx];
          e.res = pr[idx];
          e.done_cyc = cyc + latency(pa[idx], pb[idx]);
          exp_q.push_back(e);
          idx++;
        end else begin
          a = W'($urandom);
          b = W'($urandom);
          signed_mode = 1'($urandom);
        end
        @(negedge clk);
        guard++;
      end
      guard = 0;
      while (busy && guard < 20) begin
        a = W'($urandom);
        b = W'($urandom);
        @(negedge clk);
        guard++;
      end
      start = 1'b0;
      @(negedge clk);
    end
    drain();

    // Abort mid-compare: no done for it, outputs clear, next compare normal.
    a = 4'b0101;
    b = 4'b0100;
    signed_mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_results", 32'({lesser, greater, equal}), 32'd0);
    repeat (8) @(negedge clk);
    issue(4'b0101, 4'b0100, 1'b0, RES_GT);
    drain();

    // Exhaustive sweep against relational-operator reference.
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          issue(W'(x), W'(y), 1'(m), model(W'(x), W'(y), 1'(m)));
        end
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
